// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command scheduler: encoder command codes,
// encoder address map and the scheduler FSM state type.
package spi_cmd_pkg;

    // Encoder command codes carried on enc_command
    typedef enum logic [2:0] {
        GETROLLANGULAR  = 3'b000,
        GETROLLLINEAR   = 3'b001,
        GETPITCHANGULAR = 3'b010,
        GETPITCHLINEAR  = 3'b011,
        GETYAWANGULAR   = 3'b100,
        GETYAWLINEAR    = 3'b101,
        GETSTATUS       = 3'b110,
        RESETENCODER    = 3'b111
    } cmd_e;

    // Encoder bus addresses
    localparam logic [7:0] ENC_ADDR_ROLL  = 8'hA4;
    localparam logic [7:0] ENC_ADDR_PITCH = 8'hA8;

    // Scheduler FSM states
    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StAck,
        StAbort
    } sched_state_e;

endpackage

// File: rtl/spi_cmd_scheduler_if.sv
// Requester and encoder handshake bundle for spi_cmd_scheduler.
// master: requesters/encoder side; slave: the scheduler.
interface spi_cmd_scheduler_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [3*NUM_REQ-1:0] req_cmd;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   done;
    logic [NUM_REQ-1:0]   err;
    logic                 busy;
    logic                 enc_transmit;
    logic [2:0]           enc_command;
    logic                 enc_transmit_recieved;
    logic                 enc_transmission_sent;

    modport master (
        output req, req_cmd, enc_transmission_sent,
        input  grant, done, err, busy, enc_transmit, enc_command, enc_transmit_recieved
    );

    modport slave (
        input  req, req_cmd, enc_transmission_sent,
        output grant, done, err, busy, enc_transmit, enc_command, enc_transmit_recieved
    );
endinterface

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping at NUM_REQ. Returns one-hot grant, its index and a valid flag.
module spi_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    // Scan NUM_REQ positions starting at ptr, keep the first hit
    always_comb begin
        int unsigned cand;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = (32'(ptr) + off) % NUM_REQ;
            if (!valid && req[IDX_W'(cand)]) begin
                valid               = 1'b1;
                gnt[IDX_W'(cand)]   = 1'b1;
                idx                 = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/spi_cmd_scheduler.sv
// Round-robin scheduler that serialises requester commands onto one SPI
// encoder: IDLE -> ISSUE (transmit pulse) -> WAIT (for sent) -> ACK -> IDLE.
// Optional WAIT timeout with ABORT state is built when SPI_SCHED_TIMEOUT_EN
// is defined; otherwise WAIT only exits on enc_transmission_sent and err is 0.
module spi_cmd_scheduler
    import spi_cmd_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ISSUE_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic                clk,
    input logic                rst,
    spi_cmd_scheduler_if.slave bus
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    sched_state_e       state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [2:0]         cmd_q, cmd_d;
    logic [7:0]         issue_cnt_q, issue_cnt_d;
`ifdef SPI_SCHED_TIMEOUT_EN
    logic [7:0]         to_cnt_q, to_cnt_d;
`endif

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic [2:0]         win_cmd;

    spi_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req   (bus.req),
        .ptr   (rr_ptr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Select the command slice belonging to the arbitration winner
    always_comb begin
        win_cmd = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                win_cmd = bus.req_cmd[3*i +: 3];
            end
        end
    end

    // Next-state logic; counters clear whenever their state is not active
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        cmd_d       = cmd_q;
        issue_cnt_d = '0;
`ifdef SPI_SCHED_TIMEOUT_EN
        to_cnt_d    = '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    state_d = StIssue;
                    grant_d = arb_gnt;
                    owner_d = arb_idx;
                    cmd_d   = win_cmd;
                end
            end
            StIssue: begin
                if (issue_cnt_q == 8'(ISSUE_CYCLES - 1)) begin
                    state_d = StWait;
                end else begin
                    issue_cnt_d = issue_cnt_q + 8'd1;
                end
            end
            StWait: begin
`ifdef SPI_SCHED_TIMEOUT_EN
                to_cnt_d = to_cnt_q + 8'd1;
                // sent has priority over a coincident timeout
                if (bus.enc_transmission_sent) begin
                    state_d = StAck;
                end else if (to_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    state_d = StAbort;
                end
`else
                if (bus.enc_transmission_sent) begin
                    state_d = StAck;
                end
`endif
            end
            StAck, StAbort: begin
                state_d  = StIdle;
                grant_d  = '0;
                rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            cmd_q       <= 3'b000;
            issue_cnt_q <= '0;
`ifdef SPI_SCHED_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            cmd_q       <= cmd_d;
            issue_cnt_q <= issue_cnt_d;
`ifdef SPI_SCHED_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
`endif
        end
    end

    // Outputs decoded from the registered state
    always_comb begin
        bus.grant                 = grant_q;
        bus.busy                  = (state_q != StIdle);
        bus.enc_transmit          = (state_q == StIssue);
        bus.enc_command           = cmd_q;
        bus.enc_transmit_recieved = (state_q == StAck) || (state_q == StAbort);
        bus.done                  = (state_q == StAck) ? grant_q : '0;
`ifdef SPI_SCHED_TIMEOUT_EN
        bus.err                   = (state_q == StAbort) ? grant_q : '0;
`else
        bus.err                   = '0;
`endif
    end

endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// Scoreboard bench for spi_cmd_scheduler (NUM_REQ=4, ISSUE_CYCLES=2,
// TIMEOUT_CYCLES=255). Stimulus pushes expected done/err events; a monitor
// pops and compares on every done/err pulse.
module tb_spi_cmd_scheduler;

    typedef struct {
        logic       is_err;
        logic [3:0] owner;
        logic [2:0] cmd;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t sb[$];

    spi_cmd_scheduler_if #(.NUM_REQ(4)) bus ();

    spi_cmd_scheduler #(
        .NUM_REQ        (4),
        .ISSUE_CYCLES   (2),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic in_wait();
        return bus.busy && !bus.enc_transmit && !bus.enc_transmit_recieved;
    endfunction

    task automatic push(input logic is_err, input logic [3:0] owner, input logic [2:0] cmd);
        exp_t e;
        e.is_err = is_err;
        e.owner  = owner;
        e.cmd    = cmd;
        sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done != 4'b0 || bus.err != 4'b0) begin
                if (sb.size() == 0) begin
                    check("unexpected_event", int'({bus.err, bus.done}), 0);
                end else begin
                    e = sb.pop_front();
                    check("sb_done", int'(bus.done), e.is_err ? 0 : int'(e.owner));
                    check("sb_err", int'(bus.err), e.is_err ? int'(e.owner) : 0);
                    check("sb_cmd", int'(bus.enc_command), int'(e.cmd));
                    check("sb_ack", int'(bus.enc_transmit_recieved), 1);
                end
            end
        end
    endtask

    task automatic do_reset();
        rst                       = 1'b1;
        bus.req                   = '0;
        bus.req_cmd               = '0;
        bus.enc_transmission_sent = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, int'(bus.grant), 0);
        check({tag, "_done"}, int'(bus.done), 0);
        check({tag, "_err"}, int'(bus.err), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_tx"}, int'(bus.enc_transmit), 0);
        check({tag, "_cmd"}, int'(bus.enc_command), 0);
        check({tag, "_rcvd"}, int'(bus.enc_transmit_recieved), 0);
    endtask

    initial begin
        int tx;
        int w;
        int n;
        int done_at;
        int last_done;
        int ev;
        int cmd_ok;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        fork
            monitor();
        join_none

        // Reset state
        do_reset();
        check_reset_outputs("rst");

        // Single request, sent asserted on the first WAIT cycle
        bus.req_cmd = '0;
        bus.req     = 4'b0001;
        push(1'b0, 4'b0001, 3'b000);
        tx = 0; done_at = 0; cmd_ok = 1;
        for (int c = 1; c <= 12 && done_at == 0; c++) begin
            @(negedge clk);
            if (bus.enc_transmit) begin
                tx++;
                if (bus.enc_command != 3'b000 || bus.grant != 4'b0001) cmd_ok = 0;
            end
            if (in_wait()) bus.enc_transmission_sent = 1'b1;
            if (bus.done[0]) begin
                done_at                   = c;
                bus.req                   = '0;
                bus.enc_transmission_sent = 1'b0;
            end
        end
        // Request edge falls in the IDLE cycle, so done is on the 4th later
        // negedge: IDLE + 2 ISSUE + 1 WAIT + ACK = 5th cycle.
        check("single_latency", done_at, 4);
        check("single_tx_cycles", tx, 2);
        check("single_cmd_grant", cmd_ok, 1);

        // All four requesting, sent always high: order 0,1,2,3,0
        do_reset();
        bus.enc_transmission_sent = 1'b1;
        bus.req_cmd = {3'b001, 3'b110, 3'b011, 3'b101};
        bus.req     = 4'b1111;
        push(1'b0, 4'b0001, 3'b101);
        push(1'b0, 4'b0010, 3'b011);
        push(1'b0, 4'b0100, 3'b110);
        push(1'b0, 4'b1000, 3'b001);
        push(1'b0, 4'b0001, 3'b101);
        n = 0; last_done = 0;
        for (int c = 1; c <= 60 && n < 5; c++) begin
            @(negedge clk);
            if (bus.done != 4'b0) begin
                n++;
                last_done = c;
                if (n == 5) bus.req = '0;
            end
        end
        bus.enc_transmission_sent = 1'b0;
        check("rr_done_count", n, 5);
        check("rr_back_to_back", last_done, 24);

        // Requester 1, sent withheld
        do_reset();
        bus.req_cmd = {3'b000, 3'b000, 3'b011, 3'b000};
        bus.req     = 4'b0010;
`ifdef SPI_SCHED_TIMEOUT_EN
        push(1'b1, 4'b0010, 3'b011);
        w = 0; ev = 0;
        for (int c = 0; c < 400 && ev == 0; c++) begin
            @(negedge clk);
            if (in_wait()) w++;
            if (bus.err[1]) begin
                ev      = 1;
                bus.req = '0;
            end
        end
        check("timeout_err_seen", ev, 1);
        check("timeout_wait_cycles", w, 255);
        @(negedge clk);
        check("timeout_busy_drop", int'(bus.busy), 0);
`else
        push(1'b0, 4'b0010, 3'b011);
        ev = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.err != 4'b0 || bus.done != 4'b0) ev = 1;
        end
        check("no_timeout_quiet", ev, 0);
        check("no_timeout_busy", int'(bus.busy), 1);
        bus.enc_transmission_sent = 1'b1;
        ev = 0;
        for (int c = 0; c < 10 && ev == 0; c++) begin
            @(negedge clk);
            if (bus.done[1]) begin
                ev                        = 1;
                bus.req                   = '0;
                bus.enc_transmission_sent = 1'b0;
            end
        end
        check("no_timeout_late_done", ev, 1);
`endif
        bus.enc_transmission_sent = 1'b0;
        @(negedge clk);

        // Sent high through ISSUE, low for two WAIT cycles, high on the third;
        // req_cmd change mid-transaction must not leak into enc_command
        bus.req_cmd               = {3'b000, 3'b110, 3'b000, 3'b000};
        bus.req                   = 4'b0100;
        bus.enc_transmission_sent = 1'b1;
        push(1'b0, 4'b0100, 3'b110);
        tx = 0; w = 0; n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.enc_transmit) begin
                tx++;
                bus.req_cmd[8:6] = 3'b001;
            end
            if (in_wait()) begin
                w++;
                bus.enc_transmission_sent = (w >= 3);
            end
            if (bus.done != 4'b0) begin
                n++;
                bus.req                   = '0;
                bus.enc_transmission_sent = 1'b0;
            end
        end
        check("ignore_sent_done_once", n, 1);
        check("ignore_sent_wait_cycles", w, 3);
        check("ignore_sent_tx_cycles", tx, 2);

        // Reset in WAIT abandons the transaction and rewinds rr_ptr to 0
        bus.req_cmd = {3'b010, 3'b000, 3'b000, 3'b111};
        bus.req     = 4'b1000;
        w = 0;
        for (int c = 0; c < 20 && w < 2; c++) begin
            @(negedge clk);
            if (in_wait()) w++;
        end
        check("midreset_reached_wait", w, 2);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst                       = 1'b0;
        bus.req                   = 4'b1001;
        bus.enc_transmission_sent = 1'b1;
        push(1'b0, 4'b0001, 3'b111);
        ev = 0;
        for (int c = 0; c < 20 && ev == 0; c++) begin
            @(negedge clk);
            if (bus.done != 4'b0) begin
                ev                        = 1;
                bus.req                   = '0;
                bus.enc_transmission_sent = 1'b0;
            end
        end
        check("midreset_next_done", ev, 1);

        repeat (4) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_cmd_scheduler.md
SPI_CMD_SCHEDULER -- requirements
Module: spi_cmd_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of command requesters (2..8).
REQ-002 Parameter ISSUE_CYCLES, default 2, cycles enc_transmit is held high per command.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, WAIT-state cycles before abort (8-bit counter).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  NUM_REQ  per-requester command request, level, held until done or err pulse.
REQ-007 req_cmd  input  3*NUM_REQ  per-requester 3-bit command code, slice i belongs to req[i].
REQ-008 grant  output  NUM_REQ  one-hot owner of the current transaction; zero when idle.
REQ-009 done  output  NUM_REQ  one-cycle pulse on the owner bit when its command completes.
REQ-010 err  output  NUM_REQ  one-cycle pulse on the owner bit when its command times out.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 enc_transmit  output  1  drives encoder transmit.
REQ-013 enc_command  output  3  drives encoder command; stable from ISSUE entry through ACK.
REQ-014 enc_transmit_recieved  output  1  drives encoder transmitRecieved acknowledge.
REQ-015 enc_transmission_sent  input  1  encoder transmissionSent status.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT, ACK, ABORT; reset state IDLE.
REQ-017 IDLE: if any req bit high, select winner round-robin starting at rr_ptr, latch its req_cmd into enc_command, set grant one-hot, go ISSUE next cycle.
REQ-018 ISSUE: enc_transmit=1 for exactly ISSUE_CYCLES cycles, then WAIT.
REQ-019 WAIT: enc_transmit=0; on enc_transmission_sent=1 go ACK; timeout counter increments each WAIT cycle.
REQ-020 ACK: enc_transmit_recieved=1 for exactly one cycle, done[owner]=1 that cycle, then IDLE.
REQ-021 ABORT (counter reaches TIMEOUT_CYCLES in WAIT with no sent): err[owner]=1 one cycle, enc_transmit_recieved=1 that cycle to clear encoder, then IDLE.
REQ-022 rr_ptr updates to (owner+1) mod NUM_REQ on leaving ACK or ABORT; unchanged otherwise.
REQ-023 Minimum transaction latency IDLE-to-done = 1 + ISSUE_CYCLES + 1 + 1 cycles (sent on first WAIT cycle).
REQ-024 req and req_cmd changes after grant are ignored until return to IDLE; req drop mid-transaction does not abort.
REQ-025 enc_transmission_sent high during ISSUE is ignored; only sampled in WAIT.
REQ-026 Simultaneous sent and timeout in same WAIT cycle: sent wins, go ACK.
REQ-027 Back-to-back: a request pending in IDLE is granted the cycle after ACK/ABORT returns to IDLE; no idle cycle inserted beyond IDLE itself.
REQ-028 Timeout counter clears on every IDLE entry.

Reset
REQ-029 On rst=1 at clk edge: state IDLE, rr_ptr=0, counter=0, grant=0, done=0, err=0, busy=0, enc_transmit=0, enc_command=3'b000, enc_transmit_recieved=0.
REQ-030 Reset mid-transaction abandons it with no done/err pulse.

Configuration
REQ-031 Macro SPI_SCHED_TIMEOUT_EN defined: WAIT timeout and ABORT state present per REQ-021.
REQ-032 Macro undefined: no counter, ABORT unreachable, err tied to zero, WAIT exits only on sent.

Structure
REQ-033 Package spi_cmd_pkg holds command codes (GETROLLANGULAR=3'b000, GETPITCHLINEAR=3'b011, others as defined), encoder address map (0xA4, 0xA8), and FSM state enum.
REQ-034 Sub-module spi_rr_arbiter: combinational round-robin pick from req and rr_ptr, outputs one-hot and index.

Verification
REQ-035 Single req[0], cmd 3'b000, sent asserted 1 cycle into WAIT -> enc_transmit high 2 cycles, enc_command 000, done[0] pulse at cycle 5 after req.
REQ-036 req=4'b1111 continuously, immediate sent -> grants in order 0,1,2,3,0; each done pulse once per round.
REQ-037 req[1] cmd 3'b011, sent never asserted, macro defined -> err[1] pulse after 255 WAIT cycles, busy drops next cycle.
REQ-038 Same as REQ-037 with macro undefined -> busy stays high, no err; later sent=1 -> done[1].
REQ-039 sent held high during ISSUE then low, then high in WAIT cycle 3 -> ACK only after WAIT sample; done once.
REQ-040 rst pulsed during WAIT -> all outputs reset values next cycle, no done/err, next grant starts at req[0].
